// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared codes for the ALU sequencer: ALU ops, source selects, opcodes, states
package alu_seq_pkg;

  // Bit-identical to the existing ALU operation encoding.
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_BEQ = 4'b0111,
    ALU_BNE = 4'b1000,
    ALU_BLT = 4'b1001,
    ALU_BGE = 4'b1010
  } alu_op_e;

  localparam logic [1:0] SRC_A_RS1    = 2'd0;
  localparam logic [1:0] SRC_A_PC     = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INC  = 3'd1,
    S_EXEC = 3'd2,
    S_TGT  = 3'd3,
    S_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - maps latched instruction fields to the EXEC-cycle ALU controls
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic [1:0] src_a,
  output logic [1:0] src_b,
  output logic       is_branch,
  output logic       is_jump,
  output logic       illegal
);

  always_comb begin
    alu_op    = ALU_ADD;
    src_a     = SRC_A_RS1;
    src_b     = SRC_B_RS2;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_R, OPC_IMM: begin
        src_b = (opcode == OPC_IMM) ? SRC_B_IMM : SRC_B_RS2;
        case (funct3)
          3'b000: alu_op = (opcode == OPC_R && funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
          3'b111: alu_op = ALU_AND;
          3'b110: alu_op = ALU_OR;
          3'b100: alu_op = ALU_XOR;
          3'b001: alu_op = ALU_SLL;
          // SRA/SRAI is not supported by this ALU.
          3'b101: begin
            if (funct7 == FUNCT7_ALT) illegal = 1'b1;
            else                      alu_op  = ALU_SRL;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: src_b = SRC_B_IMM;
      OPC_BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_BEQ;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        is_jump = 1'b1;
        src_a   = SRC_A_OLD_PC;
        src_b   = SRC_B_IMM;
      end
      OPC_JALR: begin
        is_jump = 1'b1;
        src_b   = SRC_B_IMM;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal instruction degrades to a harmless ADD with no PC update.
    if (illegal) begin
      alu_op    = ALU_ADD;
      src_a     = SRC_A_RS1;
      src_b     = SRC_B_RS2;
      is_branch = 1'b0;
      is_jump   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle RV32 ALU sequencer: PC increment, execute, branch target, response
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_bcond,
  output logic [3:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_we,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_redirect,
  output logic       resp_illegal
);

  state_e     state;
  logic [6:0] opcode_q;
  logic [2:0] funct3_q;
  logic [6:0] funct7_q;

  logic [3:0] dec_alu_op;
  logic [1:0] dec_src_a;
  logic [1:0] dec_src_b;
  logic       dec_is_branch;
  logic       dec_is_jump;
  logic       dec_illegal;

  alu_op_decode u_decode (
    .opcode    (opcode_q),
    .funct3    (funct3_q),
    .funct7    (funct7_q),
    .alu_op    (dec_alu_op),
    .src_a     (dec_src_a),
    .src_b     (dec_src_b),
    .is_branch (dec_is_branch),
    .is_jump   (dec_is_jump),
    .illegal   (dec_illegal)
  );

  // Outputs are registered: each transition loads the controls for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      opcode_q      <= '0;
      funct3_q      <= '0;
      funct7_q      <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_redirect <= 1'b0;
      resp_illegal  <= 1'b0;
      pc_we         <= 1'b0;
      alu_op        <= ALU_ADD;
      alu_src_a     <= SRC_A_RS1;
      alu_src_b     <= SRC_B_RS2;
    end else begin
      alu_op    <= ALU_ADD;
      alu_src_a <= SRC_A_RS1;
      alu_src_b <= SRC_B_RS2;
      pc_we     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            opcode_q  <= opcode;
            funct3_q  <= funct3;
            funct7_q  <= funct7;
            req_ready <= 1'b0;
            alu_src_a <= SRC_A_PC;
            alu_src_b <= SRC_B_FOUR;
            pc_we     <= 1'b1;
            state     <= S_INC;
          end
        end
        S_INC: begin
          alu_op    <= dec_alu_op;
          alu_src_a <= dec_src_a;
          alu_src_b <= dec_src_b;
          pc_we     <= dec_is_jump;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          if (dec_is_branch && alu_bcond) begin
            alu_src_a <= SRC_A_OLD_PC;
            alu_src_b <= SRC_B_IMM;
            pc_we     <= 1'b1;
            state     <= S_TGT;
          end else begin
            resp_valid    <= 1'b1;
            resp_redirect <= dec_is_jump;
            resp_illegal  <= dec_illegal;
            state         <= S_RESP;
          end
        end
        S_TGT: begin
          resp_valid    <= 1'b1;
          resp_redirect <= 1'b1;
          resp_illegal  <= 1'b0;
          state         <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid    <= 1'b0;
            resp_redirect <= 1'b0;
            resp_illegal  <= 1'b0;
            req_ready     <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer against an instruction-level reference model
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_bcond;
  logic [3:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_we;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_redirect;
  logic       resp_illegal;

  int compared = 0;
  int mismatched = 0;

  // funct3 -> ALU op for register/immediate ALU instructions; 4'hF marks "not defined".
  localparam logic [3:0] ALU_TAB [8] = '{4'h0, 4'h5, 4'hF, 4'hF, 4'h4, 4'h6, 4'h3, 4'h2};
  localparam logic [3:0] BR_TAB  [8] = '{4'h7, 4'h8, 4'hF, 4'hF, 4'h9, 4'hA, 4'hF, 4'hF};

  alu_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .alu_bcond     (alu_bcond),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_we         (pc_we),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_redirect (resp_redirect),
    .resp_illegal  (resp_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       output logic [3:0] op, output logic [1:0] a, output logic [1:0] b,
                       output logic br, output logic jmp, output logic ill);
    op = 4'h0; a = 2'd0; b = 2'd0; br = 1'b0; jmp = 1'b0; ill = 1'b0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      op = ALU_TAB[f3];
      b  = (opc == 7'b0010011) ? 2'd1 : 2'd0;
      if (op == 4'hF) ill = 1'b1;
      if (f3 == 3'b101 && f7 == 7'b0100000) ill = 1'b1;
      if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) op = 4'h1;
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      b = 2'd1;
    end else if (opc == 7'b1100011) begin
      op  = BR_TAB[f3];
      ill = (op == 4'hF);
      br  = !ill;
    end else if (opc == 7'b1101111) begin
      a = 2'd2; b = 2'd1; jmp = 1'b1;
    end else if (opc == 7'b1100111) begin
      b = 2'd1; jmp = 1'b1;
    end else begin
      ill = 1'b1;
    end
    if (ill) op = 4'h0;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic bcond, input int hold);
    logic [3:0] eop;
    logic [1:0] ea, eb;
    logic br, jmp, ill, taken;
    model(opc, f3, f7, eop, ea, eb, br, jmp, ill);
    taken = br & bcond;
    chk("idle_req_ready", 8'(req_ready), 8'd1);
    req_valid = 1'b1; opcode = opc; funct3 = f3; funct7 = f7;
    step();
    req_valid = 1'b0;
    opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
    alu_bcond = bcond;
    chk("inc_op", 8'(alu_op), 8'h0);
    chk("inc_src_a", 8'(alu_src_a), 8'd1);
    chk("inc_src_b", 8'(alu_src_b), 8'd2);
    chk("inc_pc_we", 8'(pc_we), 8'd1);
    chk("inc_req_ready", 8'(req_ready), 8'd0);
    step();
    chk("exec_op", 8'(alu_op), 8'(eop));
    chk("exec_pc_we", 8'(pc_we), 8'(jmp));
    if (!ill) begin
      chk("exec_src_a", 8'(alu_src_a), 8'(ea));
      chk("exec_src_b", 8'(alu_src_b), 8'(eb));
    end
    chk("exec_resp_valid", 8'(resp_valid), 8'd0);
    step();
    alu_bcond = 1'b0;
    if (taken) begin
      chk("tgt_op", 8'(alu_op), 8'h0);
      chk("tgt_src_a", 8'(alu_src_a), 8'd2);
      chk("tgt_src_b", 8'(alu_src_b), 8'd1);
      chk("tgt_pc_we", 8'(pc_we), 8'd1);
      chk("tgt_resp_valid", 8'(resp_valid), 8'd0);
      step();
    end
    chk("resp_valid", 8'(resp_valid), 8'd1);
    chk("resp_redirect", 8'(resp_redirect), 8'(jmp | taken));
    chk("resp_illegal", 8'(resp_illegal), 8'(ill));
    chk("resp_pc_we", 8'(pc_we), 8'd0);
    chk("resp_ctrl", {alu_op, alu_src_a, alu_src_b}, 8'h00);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      step();
      chk("hold_resp_valid", 8'(resp_valid), 8'd1);
      chk("hold_flags", {6'd0, resp_redirect, resp_illegal}, {6'd0, jmp | taken, ill});
      chk("hold_req_ready", 8'(req_ready), 8'd0);
      chk("hold_pc_we", 8'(pc_we), 8'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("done_resp_valid", 8'(resp_valid), 8'd0);
    chk("done_req_ready", 8'(req_ready), 8'd1);
    chk("done_pc_we", 8'(pc_we), 8'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, 8'(req_ready), 8'd1);
    chk({tag, "_resp"}, {5'd0, resp_valid, resp_redirect, resp_illegal}, 8'd0);
    chk({tag, "_pc_we"}, 8'(pc_we), 8'd0);
    chk({tag, "_ctrl"}, {alu_op, alu_src_a, alu_src_b}, 8'h00);
  endtask

  initial begin
    logic [6:0] opcs [8];
    logic [6:0] opc, f7;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
             7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111};
    reset_n = 1'b0; req_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    alu_bcond = 1'b0; resp_ready = 1'b0;
    step();
    step();
    chk_reset_values("reset");
    reset_n = 1'b1;
    step();
    chk_reset_values("post_reset_idle");

    run_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0);  // ADD
    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0);  // SUB
    run_instr(7'b0110011, 3'b101, 7'b0100000, 1'b0, 0);  // SRA -> illegal
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0);  // BEQ taken
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0, 0);  // BEQ not taken
    run_instr(7'b1100111, 3'b000, 7'b0000000, 1'b1, 0);  // JALR
    run_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0, 0);  // JAL
    run_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0, 0);  // ADDI with funct7 bits set
    run_instr(7'b0010011, 3'b010, 7'b0000000, 1'b0, 0);  // SLTI -> illegal
    run_instr(7'b1100011, 3'b110, 7'b0000000, 1'b1, 0);  // BLTU -> illegal
    run_instr(7'b0110011, 3'b111, 7'b0000000, 1'b0, 5);  // AND under backpressure

    // Reset asserted mid-EXEC: outputs return to reset values without waiting for a clock edge.
    req_valid = 1'b1; opcode = 7'b1101111; funct3 = 3'b000; funct7 = 7'b0;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_reset_exec_pc_we", 8'(pc_we), 8'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_values("async_reset");
    step();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("after_reset_resp_valid", 8'(resp_valid), 8'd0);
      chk("after_reset_pc_we", 8'(pc_we), 8'd0);
      chk("after_reset_req_ready", 8'(req_ready), 8'd1);
    end

    for (int n = 0; n < 80; n++) begin
      opc = opcs[$urandom_range(0, 7)];
      if (opc == 7'b1111111) opc = 7'($urandom);
      case ($urandom_range(0, 2))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      run_instr(opc, 3'($urandom), f7, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 req_valid  input  1  instruction offered; req_ready  output  1  sequencer can accept.
REQ-004 opcode  input  7; funct3  input  3; funct7  input  7  RV32 instruction fields, sampled on accept.
REQ-005 alu_bcond  input  1  branch condition returned by the ALU in the same cycle as alu_op.
REQ-006 alu_op  output  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, BEQ 0111, BNE 1000, BLT 1001, BGE 1010.
REQ-007 alu_src_a  output  2  0=RS1, 1=PC, 2=OLD_PC; alu_src_b  output  2  0=RS2, 1=IMM, 2=FOUR.
REQ-008 pc_we  output  1  datapath writes ALU result into PC at the next edge.
REQ-009 resp_valid  output  1; resp_ready  input  1; resp_redirect  output  1; resp_illegal  output  1.

Function
REQ-010 States IDLE, INC, EXEC, TGT, RESP; req_ready=1 only in IDLE.
REQ-011 IDLE: on req_valid=1, latch opcode/funct3/funct7 and go to INC; otherwise stay.
REQ-012 INC (1 cycle): alu_op=ADD, src_a=PC, src_b=FOUR, pc_we=1; next EXEC.
REQ-013 EXEC (1 cycle), by opcode:
  - 0110011 R: src_b=RS2; funct3 000 ADD (funct7 0100000 -> SUB), 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL.
  - 0010011 I-ALU: src_b=IMM, same funct3 map, SUB never issued.
  - 0000011 LOAD / 0100011 STORE: ADD, src_a=RS1, src_b=IMM.
  - 1100011 BRANCH: src_b=RS2; funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE.
  - 1101111 JAL: ADD, src_a=OLD_PC, src_b=IMM, pc_we=1, redirect=1.
  - 1100111 JALR: ADD, src_a=RS1, src_b=IMM, pc_we=1, redirect=1.
  - src_a=RS1 unless stated.
REQ-014 EXEC branch: alu_bcond=1 -> TGT with redirect=1; alu_bcond=0 -> RESP, redirect=0.
REQ-015 TGT (1 cycle): ADD, src_a=OLD_PC, src_b=IMM, pc_we=1; next RESP.
REQ-016 Illegal: unlisted opcode, funct3 010/011 in ALU ops, funct3 101 with funct7 0100000 (SRA), branch funct3 010/011/110/111; INC still runs, EXEC issues ADD with pc_we=0, RESP with resp_illegal=1, redirect=0.
REQ-017 RESP: resp_valid=1 with redirect/illegal stable; leave to IDLE only when resp_ready=1; held indefinitely otherwise.
REQ-018 Latency accept->resp_valid: 3 cycles (non-taken), 4 cycles (taken branch); back-to-back accept earliest one cycle after RESP handshake.
REQ-019 Outside INC/EXEC/TGT: alu_op=ADD, src_a=0, src_b=0, pc_we=0.
REQ-020 pc_we asserted at most once per instruction outside INC.

Reset
REQ-021 reset_n=0 forces IDLE immediately, independent of clk.
REQ-022 Reset values: req_ready=1, resp_valid=0, resp_redirect=0, resp_illegal=0, pc_we=0, alu_op=0000, alu_src_a=0, alu_src_b=0, latched fields=0.
REQ-023 Reset mid-instruction abandons it; no pc_we or resp_valid emitted after release until a new accept.

Structure
REQ-024 Shared package alu_seq_pkg holds ALU op codes, src select codes, opcode constants, state encoding.
REQ-025 Combinational sub-module alu_op_decode maps latched fields to alu_op, src selects, is_branch, is_jump, illegal.
REQ-026 Op codes in alu_seq_pkg are bit-identical to the existing ALU encoding.

Verification
REQ-027 ADD: opcode 0110011, funct3 000, funct7 0 -> INC(ADD,PC,FOUR,pc_we), EXEC(0000,RS1,RS2), resp_valid at cycle 3, redirect=0.
REQ-028 SUB then SRA: funct7 0100000 funct3 000 -> alu_op 0001; funct3 101 -> resp_illegal=1, pc_we only in INC.
REQ-029 BEQ taken: funct3 000, alu_bcond=1 -> TGT(ADD,OLD_PC,IMM,pc_we), resp_valid cycle 4, redirect=1; bcond=0 -> cycle 3, redirect=0.
REQ-030 JALR: opcode 1100111 -> EXEC ADD RS1+IMM, pc_we=1, redirect=1, no TGT.
REQ-031 Backpressure: resp_ready=0 for 5 cycles -> resp_valid and flags stable, req_ready=0, new req_valid ignored.
REQ-032 Reset in EXEC: reset_n low mid-cycle -> outputs at reset values before next edge; no response emitted.
